// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - threshold and counter-width derivation shared by the debounce array
package debounce_pkg;

    function automatic int calc_thresh(input int clk_freq_mhz, input int jitter_max_us);
        return clk_freq_mhz * jitter_max_us;
    endfunction

    // Counter never exceeds THRESH-1; width is clamped to 1 so a bad THRESH still elaborates to the error
    function automatic int cnt_width(input int thresh);
        return (thresh < 1) ? 1 : $clog2(thresh + 1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one debounce lane: 2-flop sync, stability counter, level register, edge pulses
module debounce_channel #(
    parameter int THRESH     = 4,
    parameter int CW         = 3,
    parameter bit INIT_VALUE = 1'b0,
    parameter bit BYPASS     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic sig_i,
    output logic sig_o,
    output logic rise_o,
    output logic fall_o
);

    if (BYPASS) begin : g_bypass
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sig_o  <= INIT_VALUE;
                rise_o <= 1'b0;
                fall_o <= 1'b0;
            end else begin
                sig_o  <= sig_i;
                rise_o <= sig_i & ~sig_o;
                fall_o <= ~sig_i & sig_o;
            end
        end
    end else begin : g_filter
        localparam logic [CW-1:0] LAST = CW'(THRESH - 1);

        logic          s1;
        logic          s2;
        logic [CW-1:0] cnt;

        // Pulses are registered alongside the level so they line up with the new sig_o value
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s1     <= INIT_VALUE;
                s2     <= INIT_VALUE;
                sig_o  <= INIT_VALUE;
                cnt    <= '0;
                rise_o <= 1'b0;
                fall_o <= 1'b0;
            end else begin
                s1     <= sig_i;
                s2     <= s1;
                rise_o <= 1'b0;
                fall_o <= 1'b0;
                if (s2 == sig_o) begin
                    cnt <= '0;
                end else if (cnt != LAST) begin
                    cnt <= cnt + CW'(1);
                end else begin
                    sig_o  <= s2;
                    cnt    <= '0;
                    rise_o <= s2;
                    fall_o <= ~s2;
                end
            end
        end
    end

endmodule

// File: rtl/debounce_array.sv
// rtl/debounce_array.sv - CHANNELS independent debouncers; DEBOUNCE_BYPASS_EN swaps filtering for a plain register
module debounce_array
    import debounce_pkg::*;
#(
    parameter int CHANNELS   = 20,
    parameter int CLK_FREQ   = 50,
    parameter int JITTER_MAX = 1000,
    parameter bit INIT_VALUE = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] sig_i,
    output logic [CHANNELS-1:0] sig_o,
    output logic [CHANNELS-1:0] rise_o,
    output logic [CHANNELS-1:0] fall_o,
    output logic                changed_o
);

    localparam int THRESH = calc_thresh(CLK_FREQ, JITTER_MAX);
    localparam int CW     = cnt_width(THRESH);

`ifdef DEBOUNCE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    if (THRESH < 1) begin : g_bad_thresh
        $error("debounce_array: CLK_FREQ*JITTER_MAX must be at least 1");
    end
    if (CHANNELS < 1 || CHANNELS > 64) begin : g_bad_channels
        $error("debounce_array: CHANNELS must be within 1..64");
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        debounce_channel #(
            .THRESH    (THRESH),
            .CW        (CW),
            .INIT_VALUE(INIT_VALUE),
            .BYPASS    (BYPASS)
        ) u_channel (
            .clk   (clk),
            .rst   (rst),
            .sig_i (sig_i[i]),
            .sig_o (sig_o[i]),
            .rise_o(rise_o[i]),
            .fall_o(fall_o[i])
        );
    end

    assign changed_o = |{rise_o, fall_o};

endmodule

// File: tb/tb_debounce_array.sv
// tb/tb_debounce_array.sv - directed and randomized checks of debounce_array against a sliding-window model
module tb_debounce_array;

    localparam int CH     = 4;
    localparam int THRESH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [CH-1:0] sig_i = '0;
    logic [CH-1:0] sig_o;
    logic [CH-1:0] rise_o;
    logic [CH-1:0] fall_o;
    logic          changed_o;

    int total = 0;
    int bad   = 0;

    debounce_array #(
        .CHANNELS  (CH),
        .CLK_FREQ  (1),
        .JITTER_MAX(4),
        .INIT_VALUE(1'b0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sig_i    (sig_i),
        .sig_o    (sig_o),
        .rise_o   (rise_o),
        .fall_o   (fall_o),
        .changed_o(changed_o)
    );

    always #5 clk = ~clk;

    // Model: sig_o takes level v at an edge when the last THRESH synchronized samples all equal v
    logic [CH-1:0] m_out;
    logic [CH-1:0] m_rise;
    logic [CH-1:0] m_fall;
    logic [CH-1:0] hist[$];

    task automatic model_reset();
        m_out  = '0;
        m_rise = '0;
        m_fall = '0;
        hist.delete();
        repeat (THRESH + 1) hist.push_back('0);
    endtask

    task automatic model_edge(input logic [CH-1:0] v);
        bit all_same;
        m_rise = '0;
        m_fall = '0;
        for (int c = 0; c < CH; c++) begin
            all_same = 1'b1;
            for (int j = 1; j <= THRESH; j++)
                if (hist[j][c] !== hist[1][c]) all_same = 1'b0;
            if (all_same && hist[1][c] !== m_out[c]) begin
                m_out[c] = hist[1][c];
                if (hist[1][c]) m_rise[c] = 1'b1;
                else            m_fall[c] = 1'b1;
            end
        end
        hist.push_front(v);
        void'(hist.pop_back());
    endtask

    task automatic chk(input string tag, input logic [CH-1:0] got, input logic [CH-1:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%b want=%b", tag, got, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".sig"},  sig_o,  m_out);
        chk({tag, ".rise"}, rise_o, m_rise);
        chk({tag, ".fall"}, fall_o, m_fall);
        chk({tag, ".chg"},  {3'b0, changed_o}, {3'b0, |(m_rise | m_fall)});
    endtask

    task automatic tick(input string tag, input logic [CH-1:0] v);
        sig_i = v;
        @(posedge clk);
        model_edge(v);
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        model_reset();
        #1;
        check_outputs("reset");
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    int            chg_pulses;
    logic [CH-1:0] lvl;

    initial begin
        do_reset(2);

        // single rise on channel 0
        for (int i = 0; i < 5; i++) tick("r032_wait", 4'b0001);
        chk("r032_not_yet", sig_o, 4'b0000);
        tick("r032_edge", 4'b0001);
        chk("r032_sig", sig_o, 4'b0001);
        chk("r032_rise", rise_o, 4'b0001);
        chk("r032_chg", {3'b0, changed_o}, 4'b0001);
        tick("r032_after", 4'b0001);
        chk("r032_rise_gone", rise_o, 4'b0000);

        // short glitch on channel 1
        for (int i = 0; i < 3; i++) tick("r033_glitch", 4'b0011);
        chg_pulses = 0;
        for (int i = 0; i < 8; i++) begin
            tick("r033_hold", 4'b0001);
            chg_pulses += int'(changed_o);
        end
        chk("r033_sig", sig_o, 4'b0001);
        chk("r033_pulses", CH'(chg_pulses), 4'd0);

        // fall on channel 0
        for (int i = 0; i < 5; i++) tick("r036_wait", 4'b0000);
        tick("r036_edge", 4'b0000);
        chk("r036_fall", fall_o, 4'b0001);
        chk("r036_rise", rise_o, 4'b0000);
        chk("r036_sig", sig_o, 4'b0000);

        // all channels at once
        chg_pulses = 0;
        for (int i = 0; i < 5; i++) begin
            tick("r034_wait", 4'b1111);
            chg_pulses += int'(changed_o);
        end
        tick("r034_edge", 4'b1111);
        chg_pulses += int'(changed_o);
        chk("r034_sig", sig_o, 4'b1111);
        chk("r034_rise", rise_o, 4'b1111);
        for (int i = 0; i < 3; i++) begin
            tick("r034_hold", 4'b1111);
            chg_pulses += int'(changed_o);
        end
        chk("r034_pulses", CH'(chg_pulses), 4'd1);
        for (int i = 0; i < 8; i++) tick("r034_clear", 4'b0000);
        chk("r034_back", sig_o, 4'b0000);

        // reset in the middle of a count on channel 2
        tick("r035_pre", 4'b0100);
        tick("r035_pre", 4'b0100);
        do_reset(1);
        for (int i = 0; i < THRESH + 1; i++) tick("r035_wait", 4'b0100);
        chk("r035_not_yet", sig_o, 4'b0000);
        tick("r035_edge", 4'b0100);
        chk("r035_sig", sig_o, 4'b0100);
        chk("r035_rise", rise_o, 4'b0100);

        // random levels with occasional flips and resets
        lvl = 4'b0100;
        for (int i = 0; i < 400; i++) begin
            for (int c = 0; c < CH; c++)
                if ($urandom_range(5) == 0) lvl[c] = ~lvl[c];
            if ($urandom_range(99) == 0) do_reset(1 + int'($urandom_range(1)));
            else                         tick("rand", lvl);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
